// File: rtl/div3_res_sched_if.sv
// Request/response bundle for div3_res_sched: per-requester valid/ready with
// packed 32-bit operands, plus one tagged mod-3 response channel.
interface div3_res_sched_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic [ID_W-1:0]     rsp_id;
    logic [1:0]          rsp_r;
    logic                rsp_ready;

    modport master (
        output req_valid, req_x, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_r
    );

    modport slave (
        input  req_valid, req_x, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_r
    );
endinterface

// File: rtl/div3_res_sched.sv
// Round-robin scheduler sharing one X mod 3 residue unit between N_REQ requesters.
// Optional DIV3_SCHED_STATS_EN adds saturating grant/stall counters.
module div3_res_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    div3_res_sched_if.slave  bus
`ifdef DIV3_SCHED_STATS_EN
    ,
    output logic [15:0]      grant_cnt,
    output logic [15:0]      stall_cnt
`endif
);

    // Base-4 digit folding: 4^k == 1 (mod 3), so digit sums preserve the residue.
    function automatic logic [1:0] mod3(input logic [31:0] x);
        logic [5:0] s1;
        logic [3:0] s2;
        logic [2:0] s3;
        s1 = '0;
        for (int i = 0; i < 16; i++) begin
            s1 = s1 + {4'b0, x[2*i +: 2]};
        end
        s2 = {2'b0, s1[1:0]} + {2'b0, s1[3:2]} + {2'b0, s1[5:4]};
        s3 = {1'b0, s2[1:0]} + {1'b0, s2[3:2]};
        mod3 = (s3 >= 3'd3) ? 2'(s3 - 3'd3) : s3[1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic            vld_p1, vld_p2, arb_en;
    logic [ID_W-1:0] id_p1, id_p2, ptr;
    logic [31:0]     x_p1;
    logic [1:0]      r_p2;

    logic            move2, can_accept, gnt_hit, gnt_vld;
    logic [ID_W-1:0] gnt_id, ptr_nxt;
    logic [31:0]     gnt_x;
    logic [N_REQ-1:0] ready_vec;

    assign move2      = vld_p1 & (~vld_p2 | bus.rsp_ready);
    assign can_accept = ~vld_p1 | move2;
    assign gnt_vld    = arb_en & can_accept & gnt_hit;

    // Arbitration: rotate search starting at ptr
    always_comb begin
        gnt_hit = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_hit && bus.req_valid[idx[ID_W-1:0]]) begin
                gnt_hit = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (gnt_vld) ready_vec[gnt_id] = 1'b1;
    end

    assign gnt_x   = bus.req_x[int'(gnt_id)*32 +: 32];
    assign ptr_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_id    = id_p2;
    assign bus.rsp_r     = r_p2;

    // arb_en keeps req_ready low on the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en <= 1'b0;
            ptr    <= '0;
        end else begin
            arb_en <= 1'b1;
            if (gnt_vld) ptr <= ptr_nxt;
        end
    end

    // Stage p1: granted operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
            x_p1   <= '0;
        end else if (gnt_vld) begin
            vld_p1 <= 1'b1;
            id_p1  <= gnt_id;
            x_p1   <= gnt_x;
        end else if (move2) begin
            vld_p1 <= 1'b0;
        end
    end

    // Stage p2: registered residue and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            id_p2  <= '0;
            r_p2   <= '0;
        end else if (move2) begin
            vld_p2 <= 1'b1;
            id_p2  <= id_p1;
            r_p2   <= mod3(x_p1);
        end else if (bus.rsp_ready & vld_p2) begin
            vld_p2 <= 1'b0;
        end
    end

`ifdef DIV3_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (gnt_vld) grant_cnt <= sat_inc(grant_cnt);
            if (vld_p2 & ~bus.rsp_ready) stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_div3_res_sched.sv
// Directed-vector bench for div3_res_sched (4 requesters).
module tb_div3_res_sched;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    div3_res_sched_if #(.N_REQ(4), .ID_W(2)) bus ();

`ifdef DIV3_SCHED_STATS_EN
    logic [15:0] grant_cnt, stall_cnt;
`endif

    div3_res_sched #(.N_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DIV3_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input int i, input logic [31:0] v);
        bus.req_x[32*i +: 32] = v;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id, input logic [1:0] r);
        chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'(v));
        if (v) begin
            chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
            chk({tag, "_r"}, 32'(bus.rsp_r), 32'(r));
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    logic [1:0] fair_r [4];

    initial begin
        clk = 1'b0; rst_n = 1'b1; n_chk = 0; n_fail = 0;
        bus.req_valid = '0; bus.req_x = '0; bus.rsp_ready = 1'b1;
        fair_r = '{2'd1, 2'd2, 2'd0, 2'd0};

        // reset state, with a request pending to show ready is gated
        #2 rst_n = 1'b0;
        bus.req_valid = 4'b0001; set_x(0, 32'd10);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_valid", 32'(bus.rsp_valid), 0);
        chk("rst_id", 32'(bus.rsp_id), 0);
        chk("rst_r", 32'(bus.rsp_r), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 0);
        chk("post_rst_valid", 32'(bus.rsp_valid), 0);
        bus.req_valid = '0;
        step();

        // single request: 10 mod 3 = 1
        bus.req_valid = 4'b0001; set_x(0, 32'd10);
        #1 chk("single_ready", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        #1 chk_rsp("single_e1", 1'b0, 2'd0, 2'd0);
        step();
        #1 chk_rsp("single_e2", 1'b1, 2'd0, 2'd1);
        step();
        #1 chk_rsp("single_e3", 1'b0, 2'd0, 2'd0);

        // fairness: all four valid, ptr starts at 0
        do_reset();
        bus.rsp_ready = 1'b1;
        set_x(0, 32'd7); set_x(1, 32'd8); set_x(2, 32'd9); set_x(3, 32'hFFFF_FFFF);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("fair_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k >= 2) chk_rsp($sformatf("fair_rsp%0d", k), 1'b1, 2'((k - 2) % 4), fair_r[(k - 2) % 4]);
            else        chk_rsp($sformatf("fair_rsp%0d", k), 1'b0, 2'd0, 2'd0);
            step();
        end
        bus.req_valid = '0;
        for (int k = 8; k < 10; k++) begin
            #1 chk_rsp($sformatf("fair_drain%0d", k), 1'b1, 2'((k - 2) % 4), fair_r[(k - 2) % 4]);
            step();
        end
        #1 chk_rsp("fair_empty", 1'b0, 2'd0, 2'd0);

        // backpressure: 30 mod 3 = 0, 31 mod 3 = 1, 5 mod 3 = 2
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0110; set_x(1, 32'd30); set_x(2, 32'd31);
        #1 chk("bp_ready_c0", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = 4'b0100;
        #1 chk("bp_ready_c1", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = 4'b1000; set_x(3, 32'd5);
        for (int s = 0; s < 4; s++) begin
            #1;
            chk($sformatf("bp_stall_ready%0d", s), 32'(bus.req_ready), 0);
            chk_rsp($sformatf("bp_stall%0d", s), 1'b1, 2'd1, 2'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.req_ready), 32'b1000);
        chk_rsp("bp_drain0", 1'b1, 2'd1, 2'd0);
        step();
        bus.req_valid = '0;
        #1 chk_rsp("bp_drain1", 1'b1, 2'd2, 2'd1);
        step();
        #1 chk_rsp("bp_drain2", 1'b1, 2'd3, 2'd2);
        step();
        #1 chk_rsp("bp_empty", 1'b0, 2'd0, 2'd0);

        // pointer start at 2 with requesters 0 and 3: 100->1, 2^31->2, 3->0
        bus.req_valid = 4'b0010; set_x(1, 32'd100);
        #1 chk("ptr_ready_a", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = 4'b1001; set_x(3, 32'h8000_0000); set_x(0, 32'd3);
        #1 chk("ptr_ready_b", 32'(bus.req_ready), 32'b1000);
        chk_rsp("ptr_rsp_b", 1'b0, 2'd0, 2'd0);
        step();
        #1 chk("ptr_ready_c", 32'(bus.req_ready), 32'b0001);
        chk_rsp("ptr_rsp_c", 1'b1, 2'd1, 2'd1);
        step();
        bus.req_valid = '0;
        #1 chk_rsp("ptr_rsp_d", 1'b1, 2'd3, 2'd2);
        step();
        #1 chk_rsp("ptr_rsp_e", 1'b1, 2'd0, 2'd0);
        step();
        #1 chk_rsp("ptr_rsp_f", 1'b0, 2'd0, 2'd0);

        // reset mid-operation with both stages full (ptr is 1 here)
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111; set_x(1, 32'd11);
        step();
        step();
        #1 chk_rsp("mid_full", 1'b1, 2'd1, 2'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
        bus.req_valid = 4'b1010; bus.rsp_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        #1 chk("mid_post_ready", 32'(bus.req_ready), 0);
        step();
        #1 chk("mid_first_grant", 32'(bus.req_ready), 32'b0010);
        chk_rsp("mid_no_stale0", 1'b0, 2'd0, 2'd0);
        step();
        bus.req_valid = '0;
        #1 chk_rsp("mid_no_stale1", 1'b0, 2'd0, 2'd0);
        step();
        #1 chk_rsp("mid_rsp", 1'b1, 2'd1, 2'd2);
        step();
        #1 chk_rsp("mid_empty", 1'b0, 2'd0, 2'd0);

`ifdef DIV3_SCHED_STATS_EN
        do_reset();
        #1;
        chk("stat_grant_rst", 32'(grant_cnt), 0);
        chk("stat_stall_rst", 32'(stall_cnt), 0);
        bus.rsp_ready = 1'b1; bus.req_valid = 4'b0001; set_x(0, 32'd1);
        repeat (5) step();
        bus.req_valid = '0; bus.rsp_ready = 1'b0;
        repeat (3) step();
        #1;
        chk("stat_grant5", 32'(grant_cnt), 5);
        chk("stat_stall3", 32'(stall_cnt), 3);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        repeat (65540) step();
        #1 chk("stat_grant_sat", 32'(grant_cnt), 32'hFFFF);
        chk("stat_stall_hold", 32'(stall_cnt), 3);
        bus.req_valid = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/div3_res_sched.md
Name: div3_res_sched

Overview:
- Round-robin scheduler that shares one div_32_3_stand constant-division residue unit (X mod 3) between N_REQ requesters.
- Registers the granted operand and the residue result, as the standalone residue wrapper does.
- Adds a per-requester valid/ready request handshake and a single tagged response channel with backpressure.
- Sits between requesting datapaths and the mod-3 residue unit; accepts one operation per clock at full throughput.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, response tag width; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_x  input  32*N_REQ  operands; requester i uses bits [32*i+32:32*i+1].
- req_ready  output  N_REQ  grant/accept; at most one bit high per cycle.
- rsp_valid  output  1  result valid.
- rsp_id  output  ID_W  index of the requester that owns rsp_r.
- rsp_r  output  2  residue req_x mod 3, range 0..2.
- rsp_ready  input  1  downstream accepts the response.

Behaviour:
- State:
  - S1 (operand stage): v1, id1, x1[32:1].
  - S2 (result stage): v2, id2, r2[2:1].
  - ptr: round-robin pointer, ID_W bits.
- Outputs: rsp_valid=v2, rsp_id=id2, rsp_r=r2.
- Reset (asynchronous): v1=v2=0, id1=id2=0, x1=0, r2=0, ptr=0. All outputs are 0 during reset and on the first cycle after reset.
- Pipeline movement:
  - move2 = v1 & (~v2 | rsp_ready).
  - can_accept = ~v1 | move2.
- Arbitration:
  - Arbitration is combinational.
  - When can_accept=1, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1.
  - req_ready[i]=1 only for the granted i. All req_ready=0 when can_accept=0 or no request is pending.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Handshake: a request transfers when req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - x1 <= operand of requester i;
  - id1 <= i;
  - v1 <= 1;
  - ptr <= (i+1) mod N_REQ, wrapping from N_REQ-1 to 0.
- ptr holds its value on any cycle without a grant.
- S1 clears when move2 is taken and no new grant occurs.
- S2 update:
  - On move2: r2 <= div_32_3_stand(x1), id2 <= id1, v2 <= 1.
  - Else if rsp_ready & v2: v2 <= 0.
  - Else S2 holds.
- Latency: a request accepted at edge t gives rsp_valid=1 in the cycle after edge t+1 (2-edge latency), if not stalled.
- Throughput: one request per cycle while rsp_ready=1.
- Backpressure: while v2=1 and rsp_ready=0:
  - rsp_valid, rsp_id and rsp_r hold stable;
  - S1 holds;
  - if S1 is occupied, all req_ready=0.
  - Maximum in flight is 2.
- Simultaneous events: drain of S2, advance of S1 to S2, and a new grant into S1 may occur on the same edge.
- Requester i may keep req_valid high across grants. It regains the grant only after all other pending requesters have been served once.
- Reset mid-operation: in-flight operations are discarded with no response; ptr returns to 0.
- Residue arithmetic: rsp_r equals the unsigned 32-bit operand mod 3, with no exceptions.

Optional Feature:
- Macro: DIV3_SCHED_STATS_EN.
- When defined, adds two outputs:
  - grant_cnt, 16 bits: increments on every accepted request.
  - stall_cnt, 16 bits: increments on every cycle with v2=1 & rsp_ready=0.
  - Both saturate at 16'hFFFF and reset to 0.
- When not defined, neither port nor counter exists; the remaining behaviour is identical.

Test Plan:
- Single request: requester 0 valid with X=32'd10, rsp_ready=1 -> req_ready[0] high in the same cycle; two edges later rsp_valid=1, rsp_id=0, rsp_r=1 for one cycle.
- Fairness: all 4 requesters valid continuously, X_i = 7, 8, 9, 32'hFFFFFFFF -> grants in order 0,1,2,3,0...; responses back-to-back with r = 1, 2, 0, 0; ptr wraps from 3 to 0.
- Backpressure: rsp_ready held 0 for 4 cycles with requesters 1 and 2 valid -> after 2 acceptances all req_ready=0; rsp_id and rsp_r stay stable. On release, responses drain in grant order with no loss or duplication.
- Pointer start: ptr=2 with only requesters 0 and 3 valid -> requester 3 granted first, then requester 0.
- Reset mid-operation: assert rst_n=0 with v1=v2=1 -> rsp_valid and req_ready drop immediately; after release there are no stale responses and the first grant goes to the lowest valid index from ptr=0.
- DIV3_SCHED_STATS_EN: 5 grants and 3 stall cycles -> grant_cnt=5, stall_cnt=3; preload near 16'hFFFF -> counters saturate without wrap.
